// File: rtl/ama_riscv_hazard_pkg.sv
// Shared types and helpers for the hazard unit: scoreboard entry layout,
// the "read from regfile" forwarding code and the select-width helper.
package ama_riscv_hazard_pkg;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       load;
    } sb_entry_t;

    // Forwarding select value meaning "no forward, use regfile data"
    localparam int FWD_RF = 0;

    // Width of a forwarding select able to encode 0..stages
    function automatic int fwd_sel_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/ama_riscv_hazard_match.sv
// Per-operand priority encoder over the scoreboard: reports whether any
// tracked stage will write the operand, which stage is the youngest writer
// and whether that writer is a load.
module ama_riscv_hazard_match
    import ama_riscv_hazard_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int SELW   = fwd_sel_w(STAGES)
) (
    input  sb_entry_t [STAGES-1:0] sb,
    input  logic [4:0]             rs,
    input  logic                   rs_used,
    output logic                   hit,
    output logic [SELW-1:0]        stage,
    output logic                   is_load
);

    // Scan oldest to youngest so the lowest matching index wins
    always_comb begin
        hit     = 1'b0;
        stage   = '0;
        is_load = 1'b0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (rs_used && sb[i].valid && sb[i].we &&
                (sb[i].rd != 5'd0) && (sb[i].rd == rs)) begin
                hit     = 1'b1;
                stage   = SELW'(i);
                is_load = sb[i].load;
            end
        end
    end

endmodule

// File: rtl/ama_riscv_hazard_unit.sv
// Scoreboard-based hazard unit: forwarding selects, load-use stalls,
// memory-backpressure freeze and branch-flush clears across STAGES
// post-decode stages. Optional performance counters are enabled by
// defining HAZARD_PERF_EN.
module ama_riscv_hazard_unit
    import ama_riscv_hazard_pkg::*;
#(
    parameter int STAGES     = 2,
    parameter int LOAD_STAGE = 1,
    parameter int SELW       = fwd_sel_w(STAGES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dec_valid,
    input  logic [4:0]      rs1_dec,
    input  logic [4:0]      rs2_dec,
    input  logic            rs1_used,
    input  logic            rs2_used,
    input  logic [4:0]      rd_dec,
    input  logic            rd_we_dec,
    input  logic            load_dec,
    input  logic            flush_req,
    input  logic            mem_stall,
    output logic [SELW-1:0] fwd_a_sel,
    output logic [SELW-1:0] fwd_b_sel,
    output logic            stall_fetch,
    output logic            stall_dec,
    output logic            bubble_exe,
    output logic            clear_dec
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_mem_cnt
`endif
);

    sb_entry_t [STAGES-1:0] sb_q, sb_d;
    logic                   flush_pend_q, flush_pend_d;

    logic                   a_hit, b_hit;
    logic                   a_load, b_load;
    logic [SELW-1:0]        a_stage, b_stage;
    logic                   hazard;
    logic                   eff_flush;

    ama_riscv_hazard_match #(.STAGES(STAGES), .SELW(SELW)) u_match_rs1 (
        .sb      (sb_q),
        .rs      (rs1_dec),
        .rs_used (rs1_used),
        .hit     (a_hit),
        .stage   (a_stage),
        .is_load (a_load)
    );

    ama_riscv_hazard_match #(.STAGES(STAGES), .SELW(SELW)) u_match_rs2 (
        .sb      (sb_q),
        .rs      (rs2_dec),
        .rs_used (rs2_used),
        .hit     (b_hit),
        .stage   (b_stage),
        .is_load (b_load)
    );

    // Forwarding selects and load-use hazard detection; a load younger than
    // LOAD_STAGE has no data yet, so it stalls instead of forwarding
    always_comb begin
        fwd_a_sel = SELW'(FWD_RF);
        fwd_b_sel = SELW'(FWD_RF);
        if (a_hit && (!a_load || (a_stage >= SELW'(LOAD_STAGE))))
            fwd_a_sel = a_stage + SELW'(1);
        if (b_hit && (!b_load || (b_stage >= SELW'(LOAD_STAGE))))
            fwd_b_sel = b_stage + SELW'(1);
        hazard = dec_valid &&
                 ((a_hit && a_load && (a_stage < SELW'(LOAD_STAGE))) ||
                  (b_hit && b_load && (b_stage < SELW'(LOAD_STAGE))));
        eff_flush = flush_req || flush_pend_q;
    end

    // Pipeline control: memory freeze beats flush, flush beats load-use stall
    always_comb begin
        stall_fetch = 1'b0;
        stall_dec   = 1'b0;
        bubble_exe  = 1'b0;
        clear_dec   = 1'b0;
        if (mem_stall) begin
            stall_fetch = 1'b1;
            stall_dec   = 1'b1;
        end else if (eff_flush) begin
            clear_dec  = 1'b1;
            bubble_exe = 1'b1;
        end else if (hazard) begin
            stall_fetch = 1'b1;
            stall_dec   = 1'b1;
            bubble_exe  = 1'b1;
        end
    end

    // Scoreboard advance and deferred-flush bookkeeping; a redirect seen
    // during a memory freeze is remembered and applied on the first free cycle
    always_comb begin
        sb_d         = sb_q;
        flush_pend_d = flush_pend_q;
        if (mem_stall) begin
            if (flush_req)
                flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = 1'b0;
            for (int i = STAGES - 1; i > 0; i--)
                sb_d[i] = sb_q[i-1];
            if (dec_valid && !hazard && !eff_flush) begin
                sb_d[0].valid = 1'b1;
                sb_d[0].rd    = rd_dec;
                sb_d[0].we    = rd_we_dec;
                sb_d[0].load  = load_dec;
            end else begin
                sb_d[0] = '0;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_q         <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            sb_q         <= sb_d;
            flush_pend_q <= flush_pend_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_mem_q,   perf_mem_d;

    // Saturating event counters
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        perf_mem_d   = perf_mem_q;
        if (hazard && !mem_stall && !eff_flush && (perf_stall_q != 32'hFFFF_FFFF))
            perf_stall_d = perf_stall_q + 32'd1;
        if (eff_flush && !mem_stall && (perf_flush_q != 32'hFFFF_FFFF))
            perf_flush_d = perf_flush_q + 32'd1;
        if (mem_stall && (perf_mem_q != 32'hFFFF_FFFF))
            perf_mem_d = perf_mem_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
            perf_mem_q   <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
            perf_mem_q   <= perf_mem_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_mem_cnt   = perf_mem_q;
`endif

endmodule
